// File: rtl/data_arb_pkg.sv
// Shared types for the data BRAM arbiter: response owner tag and the
// registered response descriptor.
package data_arb_pkg;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   err;
    } resp_t;

    localparam resp_t RESP_IDLE = '{valid: 1'b0, owner: OWNER_M0, err: 1'b0};

    // Round-robin hand-off: priority goes to whichever master lost.
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWNER_M0) ? OWNER_M1 : OWNER_M0;
    endfunction

endpackage

// File: rtl/data_arb_rr.sv
// Two-way round-robin picker. Purely combinational; the caller holds the
// priority register and feeds prio_next back into it.
module data_arb_rr
    import data_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     prio,
    input  logic       advance,
    output logic [1:0] gnt,
    output owner_e     prio_next
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        gnt       = 2'b00;
        prio_next = prio;
        if (advance) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (prio == OWNER_M0) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        if (gnt[0]) prio_next = other_owner(OWNER_M0);
        if (gnt[1]) prio_next = other_owner(OWNER_M1);
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data BRAM between the core (m0) and a second
// requester (m1); out-of-range accesses get an error response, never reach memory.
module data_mem_arbiter
    import data_arb_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int RAM_DEPTH  = 1024,
    localparam int AW         = $clog2(RAM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,

    input  logic                  m0_req_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic                  m0_err_o,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_be_i,
    input  logic [31:0]           m0_wdata_i,
    output logic [31:0]           m0_rdata_o,

    input  logic                  m1_req_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic                  m1_err_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [31:0]           m1_wdata_i,
    output logic [31:0]           m1_rdata_o,

    output logic                  mem_en_o,
    output logic [3:0]            mem_we_o,
    output logic [AW-1:0]         mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    localparam logic [ADDR_WIDTH-3:0] DEPTH_WORDS = (ADDR_WIDTH-2)'(RAM_DEPTH);

    logic [1:0]            gnt;
    owner_e                prio_q;
    owner_e                prio_next;
    owner_e                sel;
    logic                  granted;
    logic                  in_range;
    logic [ADDR_WIDTH-3:0] word_addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    resp_t                 resp_q;
    logic                  rd_q;
    logic                  unused_byte_offset;

    // Byte offsets are irrelevant to a word-wide BRAM.
    assign unused_byte_offset = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

    // NOTE: rstn_i also gates the combinational grant path, so no master
    // sees a gnt (and the BRAM sees no enable) while reset is held.
    data_arb_rr u_rr (
        .req       ({m1_req_i, m0_req_i}),
        .prio      (prio_q),
        .advance   (rstn_i),
        .gnt       (gnt),
        .prio_next (prio_next)
    );

    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];
    assign granted  = |gnt;
    assign sel      = gnt[1] ? OWNER_M1 : OWNER_M0;

    always_comb begin
        word_addr = m0_addr_i[ADDR_WIDTH-1:2];
        we        = m0_we_i;
        be        = m0_be_i;
        wdata     = m0_wdata_i;
        if (sel == OWNER_M1) begin
            word_addr = m1_addr_i[ADDR_WIDTH-1:2];
            we        = m1_we_i;
            be        = m1_be_i;
            wdata     = m1_wdata_i;
        end
    end

    assign in_range    = (word_addr < DEPTH_WORDS);
    assign mem_en_o    = granted & in_range;
    assign mem_we_o    = (mem_en_o && we) ? be : 4'b0000;
    assign mem_addr_o  = word_addr[AW-1:0];
    assign mem_wdata_o = wdata;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prio_q <= OWNER_M0;
            resp_q <= RESP_IDLE;
            rd_q   <= 1'b0;
        end else begin
            prio_q <= prio_next;
            resp_q <= '{valid: granted, owner: sel, err: ~in_range};
            rd_q   <= granted & in_range & ~we;
        end
    end

    // Only an in-range read forwards BRAM data; writes and errors return zero.
    always_comb begin
        m0_rvalid_o = resp_q.valid && (resp_q.owner == OWNER_M0);
        m1_rvalid_o = resp_q.valid && (resp_q.owner == OWNER_M1);
        m0_err_o    = m0_rvalid_o & resp_q.err;
        m1_err_o    = m1_rvalid_o & resp_q.err;
        m0_rdata_o  = (m0_rvalid_o && rd_q) ? mem_rdata_i : 32'h0;
        m1_rdata_o  = (m1_rvalid_o && rd_q) ? mem_rdata_i : 32'h0;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural one-cycle BRAM
// attached to the memory port.
module tb_data_mem_arbiter;

    localparam int ADDR_WIDTH = 32;
    localparam int RAM_DEPTH  = 1024;
    localparam int AW         = 10;

    logic        clk;
    logic        rstn;
    logic        m0_req, m0_gnt, m0_rvalid, m0_err, m0_we;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_gnt, m1_rvalid, m1_err, m1_we;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    data_mem_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .RAM_DEPTH(RAM_DEPTH)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_err_o(m0_err),
        .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
        .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_err_o(m1_err),
        .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
        .m1_rdata_o(m1_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [RAM_DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_gnt(input string tag, input logic g0, input logic g1);
        check1({tag, "_m0_gnt"}, m0_gnt, g0);
        check1({tag, "_m1_gnt"}, m1_gnt, g1);
    endtask

    task automatic check_resp(input string tag,
                              input logic v0, input logic e0, input logic [31:0] d0,
                              input logic v1, input logic e1, input logic [31:0] d1);
        check1 ({tag, "_m0_rvalid"}, m0_rvalid, v0);
        check1 ({tag, "_m0_err"},    m0_err,    e0);
        check32({tag, "_m0_rdata"},  m0_rdata,  d0);
        check1 ({tag, "_m1_rvalid"}, m1_rvalid, v1);
        check1 ({tag, "_m1_err"},    m1_err,    e1);
        check32({tag, "_m1_rdata"},  m1_rdata,  d1);
    endtask

    task automatic m0_drive(input logic req, input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata);
        m0_req = req; m0_we = we; m0_addr = addr; m0_be = be; m0_wdata = wdata;
    endtask

    task automatic m1_drive(input logic req, input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata);
        m1_req = req; m1_we = we; m1_addr = addr; m1_be = be; m1_wdata = wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        m0_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        m1_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        #2;
        check_gnt("rst", 1'b0, 1'b0);
        check1 ("rst_mem_en", mem_en, 1'b0);
        check32("rst_mem_we", 32'(mem_we), 32'h0);
        check_resp("rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        m0_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        m1_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        tick();

        // First cycle after release: m0 writes DEADBEEF to 0x10.
        rstn = 1'b1;
        m0_drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        #1;
        check_gnt("t1_wr", 1'b1, 1'b0);
        check1 ("t1_wr_mem_en", mem_en, 1'b1);
        check32("t1_wr_mem_we", 32'(mem_we), 32'hF);
        check32("t1_wr_mem_addr", 32'(mem_addr), 32'h4);
        check32("t1_wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check_resp("t1_wr", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        tick();
        m0_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        m1_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        #1;
        check_gnt("t1_rd", 1'b0, 1'b1);
        check32("t1_rd_mem_we", 32'(mem_we), 32'h0);
        check32("t1_rd_mem_addr", 32'(mem_addr), 32'h4);
        check_resp("t1_rd", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        tick();
        m1_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        check_gnt("t1_idle", 1'b0, 1'b0);
        check1("t1_idle_mem_en", mem_en, 1'b0);
        check_resp("t1_idle", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);

        // Sustained contention: grants alternate m0, m1, ... one per cycle.
        for (int i = 0; i < 6; i++) begin
            tick();
            m0_drive(1'b1, 1'b1, 32'h40 + 32'(4 * i), 4'hF, 32'h100 + 32'(i));
            m1_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
            #1;
            check_gnt($sformatf("t2_c%0d", i), (i % 2) == 0, (i % 2) == 1);
            if (i == 0)
                check_resp("t2_c0", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            else if (i % 2 == 1)
                check_resp($sformatf("t2_c%0d", i), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            else
                check_resp($sformatf("t2_c%0d", i), 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        end
        tick();
        m0_drive(1'b1, 1'b0, 32'h48, 4'h0, 32'h0);
        m1_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        check_gnt("t2_rd48", 1'b1, 1'b0);
        check_resp("t2_tail", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        tick();
        m0_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        check_resp("t2_rd48", 1'b1, 1'b0, 32'h102, 1'b0, 1'b0, 32'h0);

        // Byte-lane write merge from m1.
        tick();
        m1_drive(1'b1, 1'b1, 32'h30, 4'hF, 32'h11223344);
        #1;
        check_gnt("t3_init", 1'b0, 1'b1);
        tick();
        m1_drive(1'b1, 1'b1, 32'h30, 4'b0010, 32'h0000AB00);
        #1;
        check_gnt("t3_part", 1'b0, 1'b1);
        check32("t3_part_mem_we", 32'(mem_we), 32'h2);
        check32("t3_part_mem_wdata", mem_wdata, 32'h0000AB00);
        check_resp("t3_part", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        m1_drive(1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
        #1;
        check32("t3_rd_mem_we", 32'(mem_we), 32'h0);
        tick();
        m1_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        check_resp("t3_rd", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1122AB44);

        // Range boundary: top word is valid, RAM_DEPTH*4 is an error.
        tick();
        m0_drive(1'b1, 1'b1, 32'hFFC, 4'hF, 32'hCAFEF00D);
        #1;
        check1 ("t4_top_mem_en", mem_en, 1'b1);
        check32("t4_top_mem_addr", 32'(mem_addr), 32'h3FF);
        tick();
        m0_drive(1'b1, 1'b0, 32'h1000, 4'h0, 32'h0);
        #1;
        check_gnt("t4_oor", 1'b1, 1'b0);
        check1 ("t4_oor_mem_en", mem_en, 1'b0);
        check32("t4_oor_mem_we", 32'(mem_we), 32'h0);
        check_resp("t4_top_wr", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        m0_drive(1'b1, 1'b0, 32'hFFC, 4'h0, 32'h0);
        #1;
        check1 ("t4_toprd_mem_en", mem_en, 1'b1);
        check_resp("t4_oor", 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        m0_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        check_resp("t4_toprd", 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);

        // Reset with a read response pending; priority returns to m0.
        tick();
        m0_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        #1;
        check_gnt("t5_rd", 1'b1, 1'b0);
        tick();
        rstn = 1'b0;
        m0_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        m1_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        #1;
        check_gnt("t5_rst", 1'b0, 1'b0);
        check1 ("t5_rst_mem_en", mem_en, 1'b0);
        check32("t5_rst_mem_we", 32'(mem_we), 32'h0);
        check_resp("t5_rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        rstn = 1'b1;
        #1;
        check_gnt("t5_rel0", 1'b1, 1'b0);
        check_resp("t5_rel0", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        #1;
        check_gnt("t5_rel1", 1'b0, 1'b1);
        check_resp("t5_rel1", 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        tick();
        m0_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        m1_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        check_resp("t5_rel2", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port round-robin arbiter that shares the single-port data BRAM between the core data port (m0) and a second requester such as an ML accelerator or DMA (m1). Sits between both requesters and the BRAM. Speaks the core's req/gnt/rvalid protocol on both master ports, drives a plain enable/byte-write/address port toward the BRAM, and returns each response to the master that issued it. Out-of-range accesses are rejected with an error response and never reach memory.

## Interface
- ADDR_WIDTH, 32, byte-address width of master ports
- RAM_DEPTH, 1024, BRAM depth in 32-bit words (power of two); AW = $clog2(RAM_DEPTH)
- clk_i  in  1  clock
- rstn_i  in  1  reset; one clock; reset is asynchronous and active-low
- mN_req_i  in  1  request, N = 0 (core), 1 (accelerator)
- mN_gnt_o  out  1  request accepted this cycle
- mN_rvalid_o  out  1  response valid
- mN_err_o  out  1  response is an error; qualified by mN_rvalid_o
- mN_addr_i  in  ADDR_WIDTH  byte address
- mN_we_i  in  1  1 = write
- mN_be_i  in  4  byte enables
- mN_wdata_i  in  32  write data
- mN_rdata_o  out  32  read data; qualified by mN_rvalid_o
- mem_en_o  out  1  BRAM access this cycle
- mem_we_o  out  4  byte write strobes; all zero for reads
- mem_addr_o  out  AW  word address
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  read data, valid the cycle after mem_en_o

## Operation
- Arbitration is combinational each cycle among the asserted mN_req_i.
  - Sole requester wins.
  - If both request, the master named by prio_q wins.
- prio_q points to m0 at reset. After every grant it moves to the master that was not granted.
- Exactly one mN_gnt_o is high per cycle, or none. The winner's gnt is asserted in the same cycle as its req. The loser holds its request and signals stable.
- Range check: the access is in range when addr[ADDR_WIDTH-1:2] < RAM_DEPTH.
  - In range: mem_en_o=1, mem_addr_o=addr[AW+1:2], mem_we_o = we ? be : 4'b0, mem_wdata_o = wdata.
  - Out of range: still granted, mem_en_o=0, response carries err=1.
- Response register resp_q = {valid, owner, err} is loaded on every grant.
- The next cycle, the owner gets mN_rvalid_o=1 and mN_err_o=resp_q.err.
  - rdata = mem_rdata_i for an in-range read.
  - rdata = 32'h0 for writes and errors.
- Writes also produce rvalid. The non-owner's rvalid, err and rdata stay 0.
- Fully pipelined: a new grant may occur in the same cycle as the previous response. Sustained throughput is one access per cycle.
- Masters must accept rvalid unconditionally; there is no rvalid back-pressure.

## Timing
- Grant latency is 0 cycles. Response latency is exactly 1 cycle after gnt.
- Worst-case wait under contention is 1 cycle, because of round-robin.
- While rstn_i is low:
  - all mN_gnt_o, mN_rvalid_o, mN_err_o and mem_en_o are 0; mem_we_o is 0.
  - mN_rdata_o is 0; prio_q points to m0; resp_q.valid is 0.
- Reset asserted mid-transaction: the pending response is discarded and no rvalid is produced. The BRAM write, if any, has already happened.
- A request seen on the first cycle after reset release is granted normally.
- Simultaneous requests on consecutive cycles alternate grants m0, m1, m0, ...
- Address exactly RAM_DEPTH*4 is an error. RAM_DEPTH*4-4 is in range, at the top word.

## Structure
- Package data_arb_pkg holds:
  - typedef enum logic {OWNER_M0, OWNER_M1} owner_e
  - typedef struct packed {logic valid; owner_e owner; logic err;} resp_t
- Sub-module data_arb_rr: 2-way round-robin picker.
  - Inputs: req[1:0], prio, advance.
  - Outputs: gnt[1:0] (one-hot or zero) and next prio.
- The top-level block holds the range check, the mem-port mux, resp_q and response routing.

## Test plan
- m0 writes 32'hDEADBEEF to 0x10 with be=4'hF. Next cycle, m1 reads 0x10. Expect m1_rvalid one cycle after its gnt, with m1_rdata=32'hDEADBEEF and err=0.
- Both request every cycle for 6 cycles. Expect grants m0,m1,m0,m1,m0,m1 and six rvalids, each one cycle after its gnt and routed to the correct master.
- m1 writes be=4'b0010, wdata=32'h0000AB00 over a word holding 32'h11223344, then reads it. Expect 32'h1122AB44.
- m0 reads 0x1000 (RAM_DEPTH*4). Expect gnt, mem_en_o=0, then m0_rvalid=1, m0_err=1, rdata=0. Reading 0xFFC returns data with err=0.
- Drop rstn_i in the cycle after an m0 read gnt. Expect no m0_rvalid and all outputs 0. After release, prio points to m0: simultaneous requests grant m0 first.
